// File: rtl/control_unit.sv
// Instruction sequencer: accepts one 12-bit instruction over valid/ready and drives the datapath strobes.
// Optional feature macro: CU_INSTR_COUNT_EN builds the retired-instruction counter; otherwise retired_count is 0.
`timescale 1ns/1ps

module control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [11:0] instr,
  output logic        instr_ready,
  output logic        gp_reg_read,
  output logic        gp_reg_write,
  output logic        grab_ula,
  output logic        store_data_bus,
  output logic [3:0]  ula_operation,
  output logic        imm_drive,
  output logic [7:0]  imm_data,
  output logic        done,
  output logic        illegal,
  output logic [15:0] retired_count
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1; instr is sampled only on that edge.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_OUT   = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;
  localparam logic [2:0] ST_WB    = 3'd5;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_OUT = 4'h2;

  logic [2:0]  state_q, state_d;
  logic [11:0] instr_q, instr_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;

  logic        accept;
  logic [3:0]  in_op;
  logic        in_is_alu;
  logic        in_is_illegal;
  logic        in_is_nop;

  always_comb begin
    accept        = instr_valid && (state_q == ST_IDLE);
    in_op         = instr[11:8];
    in_is_alu     = in_op[3];
    in_is_nop     = (in_op == OP_NOP);
    in_is_illegal = !in_op[3] && (in_op >= 4'h3);
  end

  // Next-state logic; NOP and illegal opcodes retire without leaving IDLE.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    done_d    = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          instr_d = instr;
          if (in_op == OP_LDI) begin
            state_d = ST_LOAD;
          end else if (in_op == OP_OUT) begin
            state_d = ST_OUT;
          end else if (in_is_alu) begin
            state_d = ST_EXEC;
          end else begin
            done_d = 1'b1;
          end
          if (in_is_illegal) begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_OUT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_EXEC: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= 12'h000;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore outputs: decoded from state_q and instr_q only, so reset clears them at once.
  always_comb begin
    instr_ready    = 1'b0;
    gp_reg_read    = 1'b0;
    gp_reg_write   = 1'b0;
    grab_ula       = 1'b0;
    store_data_bus = 1'b0;
    imm_drive      = 1'b0;
    ula_operation  = 4'h0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
      end
      ST_LOAD: begin
        imm_drive    = 1'b1;
        gp_reg_write = 1'b1;
      end
      ST_OUT: begin
        store_data_bus = 1'b1;
      end
      ST_EXEC: begin
        gp_reg_read = 1'b1;
        imm_drive   = 1'b1;
        if (instr_q[11]) begin
          ula_operation = {1'b0, instr_q[10:8]};
        end
      end
      ST_LATCH: begin
        grab_ula = 1'b1;
        if (instr_q[11]) begin
          ula_operation = {1'b0, instr_q[10:8]};
        end
      end
      ST_WB: begin
        store_data_bus = 1'b1;
        gp_reg_write   = 1'b1;
      end
      default: begin
        instr_ready = 1'b0;
      end
    endcase
  end

  assign imm_data = instr_q[7:0];
  assign done     = done_q;
  assign illegal  = illegal_q;

`ifdef CU_INSTR_COUNT_EN
  logic [15:0] retired_count_q, retired_count_d;

  // Counts alongside done_q so the new total is visible in the done cycle.
  always_comb begin
    retired_count_d = retired_count_q;
    if (done_d) begin
      retired_count_d = retired_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_count_q <= 16'h0000;
    end else begin
      retired_count_q <= retired_count_d;
    end
  end

  assign retired_count = retired_count_q;
`else
  assign retired_count = 16'h0000;
`endif

  // The shared data bus must never see two drivers.
  a_bus_exclusive: assert property (@(posedge clock) disable iff (!reset)
    !(imm_drive && store_data_bus));

  a_nop_stays_idle: assert property (@(posedge clock) disable iff (!reset)
    (accept && (in_is_nop || in_is_illegal)) |=> (state_q == ST_IDLE) && done_q);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized instructions
// checked against a per-opcode strobe table derived from the instruction set.
`timescale 1ns/1ps

module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [11:0] instr = 12'h000;
  logic        instr_ready;
  logic        gp_reg_read;
  logic        gp_reg_write;
  logic        grab_ula;
  logic        store_data_bus;
  logic [3:0]  ula_operation;
  logic        imm_drive;
  logic [7:0]  imm_data;
  logic        done;
  logic        illegal;
  logic [15:0] retired_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic        exp_illegal = 1'b0;
  logic [15:0] exp_count   = 16'h0000;

  control_unit dut (
    .clock          (clock),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_ready    (instr_ready),
    .gp_reg_read    (gp_reg_read),
    .gp_reg_write   (gp_reg_write),
    .grab_ula       (grab_ula),
    .store_data_bus (store_data_bus),
    .ula_operation  (ula_operation),
    .imm_drive      (imm_drive),
    .imm_data       (imm_data),
    .done           (done),
    .illegal        (illegal),
    .retired_count  (retired_count)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Strobe vector bit order: read, write, grab, store, imm_drive, ula_operation[3:0].
  localparam logic [8:0] S_READ  = 9'b1_0000_0000;
  localparam logic [8:0] S_WRITE = 9'b0_1000_0000;
  localparam logic [8:0] S_GRAB  = 9'b0_0100_0000;
  localparam logic [8:0] S_STORE = 9'b0_0010_0000;
  localparam logic [8:0] S_IMM   = 9'b0_0001_0000;

  function automatic int n_phases(input logic [3:0] op);
    if (op == 4'h1 || op == 4'h2) return 1;
    if (op >= 4'h8) return 3;
    return 0;
  endfunction

  function automatic logic [8:0] phase_strobes(input logic [3:0] op, input int p);
    logic [8:0] aop;
    aop = {5'b0, 1'b0, op[2:0]};
    if (op == 4'h1) return S_IMM | S_WRITE;
    if (op == 4'h2) return S_STORE;
    if (op >= 4'h8) begin
      if (p == 0) return S_READ | S_IMM | aop;
      if (p == 1) return S_GRAB | aop;
      return S_STORE | S_WRITE;
    end
    return 9'h000;
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef CU_INSTR_COUNT_EN
    return exp_count;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [8:0] obs_strobes();
    return {gp_reg_read, gp_reg_write, grab_ula, store_data_bus, imm_drive, ula_operation};
  endfunction

  // ---------------- driver ----------------
  // Presents w until accepted (bounded), then leaves the bench #1 after the acceptance edge
  // with junk on instr to show it is ignored.
  task automatic accept_instr(input logic [11:0] w, output bit ok);
    @(negedge clock);
    instr = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clock);
    ok = instr_ready;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    instr = 12'($urandom);
    if (w[11:8] >= 4'h3 && w[11:8] <= 4'h7) exp_illegal = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (obs_strobes() !== 9'h000 || instr_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0
        || retired_count !== 16'h0000 || imm_data !== 8'h00)
      $display("FAIL reset_held: strobes=%h rdy=%b done=%b ill=%b cnt=%h imm=%h, want 000 1 0 0 0000 00",
               obs_strobes(), instr_ready, done, illegal, retired_count, imm_data);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    exp_illegal = 1'b0;
    exp_count = 16'h0000;
    @(posedge clock);
    #1;
    n_checks++;
    if (obs_strobes() !== 9'h000 || instr_ready !== 1'b1 || done !== 1'b0 || retired_count !== 16'h0000)
      $display("FAIL reset_release: strobes=%h rdy=%b done=%b cnt=%h, want 000 1 0 0000",
               obs_strobes(), instr_ready, done, retired_count);
    else n_pass++;
  endtask

  task automatic test_ldi();
    bit ok;
    accept_instr(12'h15A, ok);
    n_checks++;
    if (!ok) $display("FAIL ldi_accept: instr_ready never high"); else n_pass++;
    n_checks++;
    if (obs_strobes() !== (S_IMM | S_WRITE) || imm_data !== 8'h5A || instr_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL ldi_load: strobes=%h imm=%h rdy=%b done=%b, want %h 5a 0 0",
               obs_strobes(), imm_data, instr_ready, done, S_IMM | S_WRITE);
    else n_pass++;
    @(posedge clock);
    #1;
    exp_count++;
    n_checks++;
    if (done !== 1'b1 || instr_ready !== 1'b1 || obs_strobes() !== 9'h000 || retired_count !== exp_cnt()
        || imm_data !== 8'h5A)
      $display("FAIL ldi_done: done=%b rdy=%b strobes=%h cnt=%h imm=%h, want 1 1 000 %h 5a",
               done, instr_ready, obs_strobes(), retired_count, imm_data, exp_cnt());
    else n_pass++;
  endtask

  task automatic test_alu();
    bit ok;
    logic [8:0] want [3];
    want[0] = S_READ | S_IMM | 9'h001;
    want[1] = S_GRAB | 9'h001;
    want[2] = S_STORE | S_WRITE;
    accept_instr(12'h903, ok);
    n_checks++;
    if (!ok) $display("FAIL alu_accept: instr_ready never high"); else n_pass++;
    for (int p = 0; p < 3; p++) begin
      n_checks++;
      if (obs_strobes() !== want[p] || done !== 1'b0 || instr_ready !== 1'b0 || imm_data !== 8'h03
          || (imm_drive && store_data_bus))
        $display("FAIL alu_phase%0d: strobes=%h done=%b rdy=%b imm=%h, want %h 0 0 03",
                 p, obs_strobes(), done, instr_ready, imm_data, want[p]);
      else n_pass++;
      @(posedge clock);
      #1;
    end
    exp_count++;
    n_checks++;
    if (done !== 1'b1 || instr_ready !== 1'b1 || obs_strobes() !== 9'h000 || retired_count !== exp_cnt())
      $display("FAIL alu_done: done=%b rdy=%b strobes=%h cnt=%h, want 1 1 000 %h",
               done, instr_ready, obs_strobes(), retired_count, exp_cnt());
    else n_pass++;
  endtask

  task automatic test_illegal();
    bit ok;
    accept_instr(12'h400, ok);
    exp_count++;
    n_checks++;
    if (!ok || illegal !== 1'b1 || done !== 1'b1 || obs_strobes() !== 9'h000 || instr_ready !== 1'b1
        || retired_count !== exp_cnt())
      $display("FAIL illegal_op: ok=%b ill=%b done=%b strobes=%h rdy=%b cnt=%h, want 1 1 1 000 1 %h",
               ok, illegal, done, obs_strobes(), instr_ready, retired_count, exp_cnt());
    else n_pass++;
    accept_instr(12'h1C3, ok);
    n_checks++;
    if (!ok || illegal !== 1'b1 || obs_strobes() !== (S_IMM | S_WRITE))
      $display("FAIL illegal_sticky_load: ok=%b ill=%b strobes=%h, want 1 1 %h",
               ok, illegal, obs_strobes(), S_IMM | S_WRITE);
    else n_pass++;
    @(posedge clock);
    #1;
    exp_count++;
    n_checks++;
    if (illegal !== 1'b1 || done !== 1'b1 || retired_count !== exp_cnt())
      $display("FAIL illegal_sticky_done: ill=%b done=%b cnt=%h, want 1 1 %h",
               illegal, done, retired_count, exp_cnt());
    else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    logic [11:0] w;
    int np;
    for (int t = 0; t < 40; t++) begin
      w = 12'($urandom);
      np = n_phases(w[11:8]);
      accept_instr(w, ok);
      n_checks++;
      if (!ok) $display("FAIL rand_accept[%0d]: instr_ready never high for %h", t, w); else n_pass++;
      for (int p = 0; p < np; p++) begin
        n_checks++;
        if (obs_strobes() !== phase_strobes(w[11:8], p) || imm_data !== w[7:0] || done !== 1'b0
            || instr_ready !== 1'b0)
          $display("FAIL rand_phase[%0d.%0d] instr=%h: strobes=%h imm=%h done=%b rdy=%b, want %h %h 0 0",
                   t, p, w, obs_strobes(), imm_data, done, instr_ready, phase_strobes(w[11:8], p), w[7:0]);
        else n_pass++;
        @(posedge clock);
        #1;
      end
      exp_count++;
      n_checks++;
      if (done !== 1'b1 || instr_ready !== 1'b1 || obs_strobes() !== 9'h000 || retired_count !== exp_cnt()
          || illegal !== exp_illegal || imm_data !== w[7:0])
        $display("FAIL rand_done[%0d] instr=%h: done=%b rdy=%b strobes=%h cnt=%h ill=%b imm=%h, want 1 1 000 %h %b %h",
                 t, w, done, instr_ready, obs_strobes(), retired_count, illegal, imm_data,
                 exp_cnt(), exp_illegal, w[7:0]);
      else n_pass++;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
        n_checks++;
        if (done !== 1'b0 || obs_strobes() !== 9'h000 || instr_ready !== 1'b1 || imm_data !== w[7:0])
          $display("FAIL rand_idle[%0d]: done=%b strobes=%h rdy=%b imm=%h, want 0 000 1 %h",
                   t, done, obs_strobes(), instr_ready, imm_data, w[7:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clock);
    #1;
`ifdef CU_INSTR_COUNT_EN
    @(negedge clock);
    force dut.retired_count_q = 16'hFFFE;
    #1;
    release dut.retired_count_q;
    exp_count = 16'hFFFE;
`endif
    @(negedge clock);
    instr = 12'h000;
    instr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      #1;
      exp_count++;
      n_checks++;
      if (done !== 1'b1 || instr_ready !== 1'b1 || retired_count !== exp_cnt())
        $display("FAIL b2b_nop[%0d]: done=%b rdy=%b cnt=%h, want 1 1 %h",
                 k, done, instr_ready, retired_count, exp_cnt());
      else n_pass++;
    end
    @(negedge clock);
    instr = 12'h1AA;
    @(posedge clock);
    #1;
    n_checks++;
    if (done !== 1'b0 || obs_strobes() !== (S_IMM | S_WRITE) || imm_data !== 8'hAA)
      $display("FAIL b2b_ldi_load: done=%b strobes=%h imm=%h, want 0 %h aa",
               done, obs_strobes(), imm_data, S_IMM | S_WRITE);
    else n_pass++;
    @(negedge clock);
    instr = 12'h000;
    @(posedge clock);
    #1;
    exp_count++;
    n_checks++;
    if (done !== 1'b1 || instr_ready !== 1'b1 || retired_count !== exp_cnt())
      $display("FAIL b2b_ldi_done: done=%b rdy=%b cnt=%h, want 1 1 %h", done, instr_ready, retired_count, exp_cnt());
    else n_pass++;
    @(posedge clock);
    #1;
    exp_count++;
    n_checks++;
    if (done !== 1'b1 || retired_count !== exp_cnt() || imm_data !== 8'h00)
      $display("FAIL b2b_nop_after_ldi: done=%b cnt=%h imm=%h, want 1 %h 00", done, retired_count, imm_data, exp_cnt());
    else n_pass++;
    @(negedge clock);
    instr_valid = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (done !== 1'b0 || instr_ready !== 1'b1)
      $display("FAIL b2b_drain: done=%b rdy=%b, want 0 1", done, instr_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    accept_instr(12'hC33, ok);
    n_checks++;
    if (!ok || obs_strobes() !== (S_READ | S_IMM | 9'h004))
      $display("FAIL mid_exec: ok=%b strobes=%h, want 1 %h", ok, obs_strobes(), S_READ | S_IMM | 9'h004);
    else n_pass++;
    @(posedge clock);
    #1;
    n_checks++;
    if (obs_strobes() !== (S_GRAB | 9'h004))
      $display("FAIL mid_latch: strobes=%h, want %h", obs_strobes(), S_GRAB | 9'h004);
    else n_pass++;
    #2;
    reset = 1'b0;
    exp_illegal = 1'b0;
    exp_count = 16'h0000;
    #1;
    n_checks++;
    if (grab_ula !== 1'b0 || obs_strobes() !== 9'h000 || instr_ready !== 1'b1 || done !== 1'b0
        || illegal !== 1'b0 || retired_count !== 16'h0000 || imm_data !== 8'h00)
      $display("FAIL mid_async_reset: strobes=%h rdy=%b done=%b ill=%b cnt=%h imm=%h, want 000 1 0 0 0000 00",
               obs_strobes(), instr_ready, done, illegal, retired_count, imm_data);
    else n_pass++;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if (done !== 1'b0 || obs_strobes() !== 9'h000 || instr_ready !== 1'b1 || retired_count !== exp_cnt())
        $display("FAIL mid_after[%0d]: done=%b strobes=%h rdy=%b cnt=%h, want 0 000 1 %h",
                 k, done, obs_strobes(), instr_ready, retired_count, exp_cnt());
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ldi();
    test_alu();
    test_illegal();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
